// File: rtl/vecgen_ctrl_seq.sv
// vecgen_ctrl_seq: walks in rows x PE groups x kernel rows/cols and emits the vectorgen ctrl word per beat.
// Optional VECGEN_SEQ_PERF_EN adds perf_beats/perf_stalls counters.
module vecgen_ctrl_seq #(
  parameter int NUM_PE        = 4,
  parameter int DIM_W         = 10,
  parameter int KDIM_W        = 4,
  parameter int PAD_WIDTH     = 3,
  parameter int CTRL_DELAY    = 2,
  parameter int DRAIN_CYC     = 6,
  parameter int VECGEN_CTRL_W = 9
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [DIM_W-1:0]         cfg_in_h,
  input  logic [DIM_W-1:0]         cfg_out_w,
  input  logic [DIM_W-1:0]         cfg_out_h,
  input  logic [KDIM_W-1:0]        cfg_k_w,
  input  logic [KDIM_W-1:0]        cfg_k_h,
  input  logic [PAD_WIDTH-1:0]     cfg_pad,
  input  logic [DIM_W-1:0]         cfg_num_fm,
  input  logic                     ready,
  input  logic                     stall,
  output logic [VECGEN_CTRL_W-1:0] ctrl,
  output logic                     busy,
  output logic                     done
`ifdef VECGEN_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_beats,
  output logic [31:0]              perf_stalls
`endif
);
  localparam int PE_SH = $clog2(NUM_PE);
  localparam int DR_W  = $clog2(DRAIN_CYC + 2);
  if (NUM_PE < 1 || (NUM_PE & (NUM_PE - 1)) != 0 || VECGEN_CTRL_W != 9) begin : g_bad
    $error("vecgen_ctrl_seq: NUM_PE must be a power of 2 and VECGEN_CTRL_W must be 9");
  end
  typedef enum logic [2:0] {IDLE, START, RUN, GAP, NEXTFM, DRAIN, DONE} state_t;
  state_t st_q;
  logic [DIM_W-1:0] inh_q, outh_q, g_q, nfm_q, fm_q, ih_q, og_q, ih_d, og_d;
  logic [KDIM_W-1:0] kwc_q, khc_q, kw_q, kh_q, khmax_q, kw_d, kh_d, khmax_d, kh_min, nmax;
  logic [PAD_WIDTH-1:0] pad_q;
  logic [DR_W-1:0] drain_q;
  logic [DIM_W:0] ih1, kh_ext;
  logic signed [DIM_W:0] eff_w;
  logic beat, hold, last_kw, last_kh, last_og, last_ih, wkh, wog, first;
  logic rd, nd, er, nr, pop_u, shf_u, skp_u;
  logic [2:0] bits_u, bits_o;
  assign beat    = st_q == RUN && !stall;
  assign hold    = st_q == RUN && stall;
  assign ih1     = (DIM_W+1)'(ih_q) + (DIM_W+1)'(1);
  assign kh_ext  = (DIM_W+1)'(khc_q);
  assign kh_min  = ih1 < kh_ext ? KDIM_W'(kh_ext - ih1) : '0;
  assign last_kw = kw_q == kwc_q - KDIM_W'(1);
  assign last_kh = kh_q == kh_min;
  assign last_og = og_q == g_q - DIM_W'(1);
  assign last_ih = ih_q == inh_q - DIM_W'(1);
  assign wkh     = last_kw && last_kh;
  assign wog     = wkh && last_og;
  assign first   = kw_q == '0 && kh_q == khmax_q;
  // Rows past the last output row lose one kernel row each.
  assign nmax    = ih1 < (DIM_W+1)'(outh_q) ? khc_q - KDIM_W'(1) : khmax_q - KDIM_W'(1);
  assign kw_d    = last_kw ? '0 : kw_q + KDIM_W'(1);
  assign kh_d    = !last_kw ? kh_q : !last_kh ? kh_q - KDIM_W'(1) : !last_og ? khmax_q : nmax;
  assign og_d    = !wkh ? og_q : last_og ? '0 : og_q + DIM_W'(1);
  assign ih_d    = wog ? ih_q + DIM_W'(1) : ih_q;
  assign khmax_d = wog ? nmax : khmax_q;
  assign eff_w   = $signed((DIM_W+1)'(kwc_q)) - $signed((DIM_W+1)'({pad_q, 1'b0}));
  assign rd      = beat && first && (ih_q != '0 || og_q != '0);
  assign nd      = rd && !(last_ih && last_og);
  assign er      = rd && last_og;
  assign nr      = beat && first && og_q == '0 && ih_q != '0;
  assign pop_u   = beat && kw_q == '0;
  assign shf_u   = beat && kw_q != '0;
  assign skp_u   = pop_u && last_kh && last_og && !last_ih && eff_w > $signed((DIM_W+1)'(NUM_PE));
  assign bits_u  = {pop_u, shf_u, skp_u};
  if (CTRL_DELAY == 0) begin : g_nopipe
    assign bits_o = bits_u;
  end else begin : g_pipe
    logic [2:0] pipe_q [CTRL_DELAY];
    always_ff @(posedge clk or posedge reset)
      if (reset) for (int i = 0; i < CTRL_DELAY; i++) pipe_q[i] <= '0;
      else if (!hold) begin
        pipe_q[0] <= bits_u;
        for (int i = 1; i < CTRL_DELAY; i++) pipe_q[i] <= pipe_q[i-1];
      end
    assign bits_o = hold ? '0 : pipe_q[CTRL_DELAY-1];
  end
  assign ctrl = {nd, rd, bits_o[2], bits_o[1], nr, bits_o[0], er, st_q == START, st_q == NEXTFM};
  assign busy = st_q != IDLE;
  assign done = st_q == DONE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      st_q <= IDLE;
      {inh_q, outh_q, g_q, nfm_q, fm_q, ih_q, og_q} <= '0;
      {kwc_q, khc_q, kw_q, kh_q, khmax_q} <= '0;
      pad_q   <= '0;
      drain_q <= '0;
    end else begin
      case (st_q)
        IDLE: if (start) begin
          inh_q   <= cfg_in_h;
          outh_q  <= cfg_out_h;
          g_q     <= cfg_out_w >> PE_SH;
          nfm_q   <= cfg_num_fm;
          kwc_q   <= cfg_k_w;
          khc_q   <= cfg_k_h;
          pad_q   <= cfg_pad;
          fm_q    <= '0;
          ih_q    <= '0;
          og_q    <= '0;
          kw_q    <= '0;
          kh_q    <= cfg_k_h - KDIM_W'(1);
          khmax_q <= cfg_k_h - KDIM_W'(1);
          st_q    <= START;
        end
        START: if (ready) st_q <= RUN;
        RUN: if (beat) begin
          kw_q    <= kw_d;
          kh_q    <= kh_d;
          og_q    <= og_d;
          ih_q    <= ih_d;
          khmax_q <= khmax_d;
          if (wog && last_ih) st_q <= GAP;
        end
        GAP: st_q <= NEXTFM;
        NEXTFM: if (fm_q + DIM_W'(1) < nfm_q) begin
          fm_q    <= fm_q + DIM_W'(1);
          ih_q    <= '0;
          og_q    <= '0;
          kw_q    <= '0;
          kh_q    <= khc_q - KDIM_W'(1);
          khmax_q <= khc_q - KDIM_W'(1);
          st_q    <= START;
        end else begin
          drain_q <= '0;
          st_q    <= DRAIN_CYC == 0 ? DONE : DRAIN;
        end
        DRAIN: begin
          drain_q <= drain_q + DR_W'(1);
          if (drain_q == DR_W'(DRAIN_CYC - 1)) st_q <= DONE;
        end
        DONE: st_q <= IDLE;
        default: st_q <= IDLE;
      endcase
    end
`ifdef VECGEN_SEQ_PERF_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      perf_beats  <= '0;
      perf_stalls <= '0;
    end else if (st_q == IDLE && start) begin
      perf_beats  <= '0;
      perf_stalls <= '0;
    end else begin
      if (beat && perf_beats != '1) perf_beats <= perf_beats + 32'd1;
      if (hold && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
    end
`endif
endmodule
